instruction_queue: RTL and testbench

Instruction buffer between the fetch stage and decode. Captures each fetched (PC, instruction) pair into a small FIFO so fetch keeps running while decode stalls. Presents the oldest entry to decode with a valid/ready handshake. Discards all buffered entries in one cycle on a branch redirect.

---
 rtl/instruction_queue.sv | 122 ++++++++++++
 tb/tb_instruction_queue.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/instruction_queue.sv
// ---------------------------------------------------------------------------
// instruction_queue
//
// Purpose:
//   Small FIFO between fetch and decode. Each fetched (PC, instruction) pair
//   is captured so fetch can keep running while decode stalls. The oldest
//   entry is presented to decode with a valid/ready handshake
//   (first-word fall-through). A branch redirect (flush) discards every
//   buffered entry in a single cycle.
//
// Parameters:
//   DEPTH  number of entries (power of two, >= 2)
//   WIDTH  instruction word width in bits
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   reset      synchronous active-high reset (priority over flush)
//   flush      branch redirect, empties the queue at the next edge
//   in_valid   fetch is presenting an entry
//   in_pc      PC of the fetched instruction
//   in_instr   fetched instruction word
//   in_ready   queue can accept an entry this cycle
//   out_valid  head entry is valid
//   out_pc     PC of the head entry (0 when empty)
//   out_instr  instruction word of the head entry (0 when empty)
//   out_ready  decode consumes the head entry this cycle
//   count      current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module instruction_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [31:0]                in_pc,
    input  logic [WIDTH-1:0]           in_instr,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [31:0]                out_pc,
    output logic [WIDTH-1:0]           out_instr,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [31:0]      r_pcMem    [DEPTH];
    logic [WIDTH-1:0] r_instrMem [DEPTH];
    logic [PW-1:0]    r_rdPtr;
    logic [PW-1:0]    r_wrPtr;
    logic [CW-1:0]    r_count;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;

    // Handshake flags depend only on registered occupancy, so in_ready never
    // looks at out_ready: a full queue refuses a push even when a pop frees a
    // slot at the same edge.
    always_comb begin
        w_empty = (r_count == '0);
        w_full  = (r_count == FULL_COUNT);
        w_push  = in_valid && !w_full;
        w_pop   = out_ready && !w_empty;
    end

    // Head entry falls through combinationally; outputs are forced to zero
    // while empty so stale storage is never visible.
    always_comb begin
        in_ready  = !w_full;
        out_valid = !w_empty;
        count     = r_count;
        out_pc    = '0;
        out_instr = '0;
        if (!w_empty) begin
            out_pc    = r_pcMem[r_rdPtr];
            out_instr = r_instrMem[r_rdPtr];
        end
    end

    // Storage is deliberately not reset. A push in a reset or flush cycle is
    // dropped, so the array is only written for accepted entries.
    always_ff @(posedge clk) begin
        if (w_push && !reset && !flush) begin
            r_pcMem[r_wrPtr]    <= in_pc;
            r_instrMem[r_wrPtr] <= in_instr;
        end
    end

    // Pointers and occupancy. Reset and flush both return the queue to empty
    // and cancel any handshake in that cycle. Pointers wrap naturally because
    // DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_queue.sv
// ---------------------------------------------------------------------------
// tb_instruction_queue
//
// Purpose:
//   Self-checking bench for instruction_queue. Directed scenarios use
//   constant expectations; the random scenario compares against a queue
//   model of FIFO behaviour kept in the bench.
// ---------------------------------------------------------------------------
module tb_instruction_queue;

    localparam int DEPTH = 4;
    localparam int WIDTH = 32;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic [31:0]      in_pc;
    logic [WIDTH-1:0] in_instr;
    logic             in_ready;
    logic             out_valid;
    logic [31:0]      out_pc;
    logic [WIDTH-1:0] out_instr;
    logic             out_ready;
    logic [CW-1:0]    count;

    int checks = 0;
    int errors = 0;

    // Reference model: oldest entry at index 0, each element is {pc, instr}.
    logic [31+WIDTH:0] model[$];

    instruction_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .out_ready (out_ready),
        .count     (count)
    );

    always #5 clk = ~clk;

    // Advance one clock edge, updating the model from the current inputs.
    // A push is accepted only when the queue was not full before the edge.
    task automatic tick();
        bit doPop;
        bit doPush;
        if (reset || flush) begin
            model.delete();
        end else begin
            doPop  = out_ready && (model.size() != 0);
            doPush = in_valid && (model.size() != DEPTH);
            if (doPop) void'(model.pop_front());
            if (doPush) model.push_back({in_pc, in_instr});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_entry(input logic [31:0] pc, input logic [WIDTH-1:0] instr);
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = instr;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_out_pc: got %h expected 0", out_pc); end
        checks++; if (out_instr !== 32'h0) begin errors++; $display("[TB] FAIL reset_out_instr: got %h expected 0", out_instr); end
    endtask

    task automatic test_in_order();
        out_ready = 1'b0;
        push_entry(32'h0, 32'hE3A00001);
        checks++; if (out_pc !== 32'h0 || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL order_visible: got pc %h valid %b expected pc 0 valid 1", out_pc, out_valid); end
        push_entry(32'h4, 32'hE3A01002);
        checks++; if (count !== 3'd2) begin errors++; $display("[TB] FAIL order_count: got %0d expected 2", count); end
        checks++; if (out_pc !== 32'h0 || out_instr !== 32'hE3A00001) begin errors++; $display("[TB] FAIL order_head0: got %h/%h expected 0/e3a00001", out_pc, out_instr); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_pc !== 32'h4 || out_instr !== 32'hE3A01002) begin errors++; $display("[TB] FAIL order_head1: got %h/%h expected 4/e3a01002", out_pc, out_instr); end
        tick();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin errors++; $display("[TB] FAIL order_drained: got valid %b count %0d expected 0 0", out_valid, count); end
    endtask

    task automatic test_full();
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) push_entry(32'(i * 4), 32'hA000_0000 + 32'(i));
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_in_ready: got %b expected 0", in_ready); end
        checks++; if (count !== 3'd4) begin errors++; $display("[TB] FAIL full_count: got %0d expected 4", count); end
        in_valid  = 1'b1;
        in_pc     = 32'h10;
        in_instr  = 32'hDEAD_BEEF;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        checks++; if (count !== 3'd3) begin errors++; $display("[TB] FAIL full_pop_only_count: got %0d expected 3", count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL full_in_ready_rise: got %b expected 1", in_ready); end
        for (int i = 1; i < DEPTH; i++) begin
            checks++; if (out_pc !== 32'(i * 4) || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL full_drain: got pc %h valid %b expected pc %h valid 1", out_pc, out_valid, 32'(i * 4)); end
            tick();
        end
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL full_no_extra: got valid %b pc %h expected valid 0", out_valid, out_pc); end
    endtask

    task automatic test_stream();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_pc    = 32'h200 + 32'(k * 4);
            in_instr = 32'h5500_0000 + 32'(k);
            tick();
            checks++; if (count !== 3'd1) begin errors++; $display("[TB] FAIL stream_count: got %0d expected 1 at step %0d", count, k); end
            checks++; if (out_pc !== 32'h200 + 32'(k * 4) || out_instr !== 32'h5500_0000 + 32'(k)) begin errors++; $display("[TB] FAIL stream_head: got %h/%h expected %h/%h", out_pc, out_instr, 32'h200 + 32'(k * 4), 32'h5500_0000 + 32'(k)); end
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stream_drain: got valid %b expected 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_entry(32'h30 + 32'(i * 4), 32'h1111_0000 + 32'(i));
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_pc     = 32'h20;
        in_instr  = 32'h2222_2222;
        out_ready = 1'b1;
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_empty: got count %0d valid %b ready %b expected 0 0 1", count, out_valid, in_ready); end
        push_entry(32'h100, 32'h3333_3333);
        checks++; if (out_pc !== 32'h100 || count !== 3'd1) begin errors++; $display("[TB] FAIL flush_repush: got pc %h count %0d expected 100 1", out_pc, count); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0;
        push_entry(32'h40, 32'h4444_0000);
        push_entry(32'h44, 32'h4444_0001);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_pc    = 32'h48;
        in_instr = 32'h4444_0002;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        checks++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL midreset_flags: got count %0d valid %b ready %b expected 0 0 1", count, out_valid, in_ready); end
        checks++; if (out_pc !== 32'h0 || out_instr !== 32'h0) begin errors++; $display("[TB] FAIL midreset_data: got %h/%h expected 0/0", out_pc, out_instr); end
    endtask

    task automatic test_random();
        int               expCount;
        logic [31:0]      expPc;
        logic [WIDTH-1:0] expInstr;
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            in_pc     = {$urandom_range(0, 32'h0FFF_FFFF), 2'b00} ;
            in_instr  = $urandom;
            tick();
            flush    = 1'b0;
            expCount = model.size();
            expPc    = (expCount != 0) ? model[0][31+WIDTH:WIDTH] : 32'h0;
            expInstr = (expCount != 0) ? model[0][WIDTH-1:0] : '0;
            checks++; if (count !== CW'(expCount)) begin errors++; $display("[TB] FAIL rand_count: got %0d expected %0d at %0d", count, expCount, i); end
            checks++; if (out_valid !== (expCount != 0)) begin errors++; $display("[TB] FAIL rand_out_valid: got %b expected %b at %0d", out_valid, expCount != 0, i); end
            checks++; if (in_ready !== (expCount != DEPTH)) begin errors++; $display("[TB] FAIL rand_in_ready: got %b expected %b at %0d", in_ready, expCount != DEPTH, i); end
            checks++; if (out_pc !== expPc || out_instr !== expInstr) begin errors++; $display("[TB] FAIL rand_head: got %h/%h expected %h/%h at %0d", out_pc, out_instr, expPc, expInstr, i); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_instr  = '0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_in_order();
        test_full();
        test_stream();
        test_flush();
        test_reset_midflight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
